dcache_axi_master: RTL and testbench

//  Memory-side responder for the L1 data cache request port (D_req/D_addr/D_write/D_in/D_type).

---
 rtl/dcache_axi_master_pkg.sv | 29 ++
 rtl/dcache_wstrb_align.sv | 25 ++
 rtl/dcache_axi_master.sv | 176 +++++++++++++++++
 tb/tb_dcache_axi_master.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_axi_master_pkg.sv
// Shared definitions for the D-cache AXI master: cache access-type encodings,
// AXI burst/size/response constants and the transaction FSM state type.
// No ports (package).
package dcache_axi_master_pkg;

    // Access types presented on D_type by the core.
    localparam logic [2:0] CACHE_BYTE    = 3'b000;
    localparam logic [2:0] CACHE_HWORD   = 3'b001;
    localparam logic [2:0] CACHE_WORD    = 3'b010;
    localparam logic [2:0] CACHE_BYTE_U  = 3'b100;
    localparam logic [2:0] CACHE_HWORD_U = 3'b101;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [3:0] LINE_LEN = 4'd3;   // 4-beat line fill
    localparam logic [3:0] ONE_LEN  = 4'd0;   // single beat

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_WR,
        ST_B,
        ST_DONE
    } state_t;

endpackage

// File: rtl/dcache_wstrb_align.sv
// Write-strobe generator: maps access type and low address bits to the
// byte lanes of a 32-bit write. Signed/unsigned variants of a size share
// the same lanes; word and any unknown type enable all four lanes.
// Ports:
//   d_type  in  3  access type
//   addr_lo in  2  address bits [1:0]
//   wstrb   out 4  byte-lane strobes
module dcache_wstrb_align
    import dcache_axi_master_pkg::*;
(
    input  logic [2:0] d_type,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb
);

    always_comb begin
        wstrb = 4'b1111;
        case (d_type)
            CACHE_BYTE, CACHE_BYTE_U:   wstrb = 4'b0001 << addr_lo;
            CACHE_HWORD, CACHE_HWORD_U: wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            default:                    wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/dcache_axi_master.sv
// Memory-side responder for the L1 D-cache request port. Each held-level
// request becomes one AXI transaction: a 4-beat INCR line fill, a 1-beat
// uncached read, or a 1-beat write. RDATA is passed straight to D_out.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   D_req/D_write                 read / write request levels (held)
//   D_addr, D_in, D_type          request address, write data, access type
//   D_out                         read data (RDATA passthrough)
//   busy                          transaction in flight
//   resp_err                      sticky non-OKAY response / short burst flag
//   AR*/R*, AW*/W*, B*            AXI master channels
module dcache_axi_master
    import dcache_axi_master_pkg::*;
#(
    parameter logic [3:0]  MASTER_ID    = 4'd1,
    parameter logic [15:0] UNCACHED_HI0 = 16'h1000,
    parameter logic [15:0] UNCACHED_HI1 = 16'h6000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        D_req,
    input  logic [31:0] D_addr,
    input  logic        D_write,
    input  logic [31:0] D_in,
    input  logic [2:0]  D_type,
    output logic [31:0] D_out,
    output logic        busy,
    output logic        resp_err,
    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    output logic [3:0]  AWID,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [3:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY
);

    state_t      state, state_n;
    logic [31:0] addr_r;
    logic [31:0] ar_addr_r;
    logic [3:0]  len_r;
    logic [31:0] data_r;
    logic [3:0]  strb_r;
    logic [3:0]  strb_c;
    logic [1:0]  beat_cnt;
    logic        aw_done;
    logic        w_done;
    logic        uncached_c;

    // Only one transaction is ever outstanding, so the IDs carry no information.
    logic unused_ids;
    assign unused_ids = ^{RID, BID};

    dcache_wstrb_align u_wstrb (
        .d_type  (D_type),
        .addr_lo (D_addr[1:0]),
        .wstrb   (strb_c)
    );

    assign uncached_c = (D_addr[31:16] == UNCACHED_HI0) ||
                        (D_addr[31:16] == UNCACHED_HI1);

    // All channel outputs derive from registered state only, so no READY
    // input can reach a VALID output combinationally.
    assign ARID    = MASTER_ID;
    assign ARADDR  = ar_addr_r;
    assign ARLEN   = len_r;
    assign ARSIZE  = AXI_SIZE_4B;
    assign ARBURST = AXI_BURST_INCR;
    assign ARVALID = (state == ST_AR);
    assign RREADY  = (state == ST_R);

    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_r;
    assign AWLEN   = ONE_LEN;
    assign AWSIZE  = AXI_SIZE_4B;
    assign AWBURST = AXI_BURST_INCR;
    assign AWVALID = (state == ST_WR) && !aw_done;
    assign WDATA   = data_r;
    assign WSTRB   = strb_r;
    assign WLAST   = 1'b1;
    assign WVALID  = (state == ST_WR) && !w_done;
    assign BREADY  = (state == ST_B);

    assign D_out = RDATA;
    assign busy  = (state != ST_IDLE);

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (D_write)    state_n = ST_WR;
                else if (D_req) state_n = ST_AR;
            end
            ST_AR:   if (ARREADY) state_n = ST_R;
            ST_R:    if (RVALID && RLAST) state_n = ST_DONE;
            // A channel already accepted counts as done; otherwise its VALID
            // is high and its READY alone completes the handshake.
            ST_WR:   if ((aw_done || AWREADY) && (w_done || WREADY)) state_n = ST_B;
            ST_B:    if (BVALID) state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_r    <= 32'd0;
            ar_addr_r <= 32'd0;
            len_r     <= 4'd0;
            data_r    <= 32'd0;
            strb_r    <= 4'd0;
            beat_cnt  <= 2'd0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (D_write || D_req) begin
                        addr_r    <= D_addr;
                        data_r    <= D_in;
                        strb_r    <= strb_c;
                        ar_addr_r <= uncached_c ? D_addr : {D_addr[31:4], 4'b0000};
                        len_r     <= uncached_c ? ONE_LEN : LINE_LEN;
                        beat_cnt  <= 2'd0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                    end
                end
                ST_R: begin
                    if (RVALID) begin
                        if (beat_cnt != 2'd3) beat_cnt <= beat_cnt + 2'd1;
                        if (RRESP != AXI_RESP_OKAY) resp_err <= 1'b1;
                        // RLAST before the fourth beat of a line fill is a protocol error.
                        if (RLAST && (len_r == LINE_LEN) && (beat_cnt != 2'd3))
                            resp_err <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (AWVALID && AWREADY) aw_done <= 1'b1;
                    if (WVALID && WREADY)   w_done  <= 1'b1;
                end
                ST_B: begin
                    if (BVALID && (BRESP != AXI_RESP_OKAY)) resp_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_axi_master.sv
// Self-checking bench for dcache_axi_master. Inputs change on the falling
// edge; outputs are sampled on the falling edge. A behavioural model
// predicts addresses, burst lengths, strobes, read data and the sticky
// error flag from the request alone.
module tb_dcache_axi_master;
    import dcache_axi_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        D_req, D_write;
    logic [31:0] D_addr, D_in;
    logic [2:0]  D_type;
    logic [31:0] D_out;
    logic        busy, resp_err;
    logic [3:0]  ARID, ARLEN, AWID, AWLEN;
    logic [31:0] ARADDR, AWADDR, WDATA;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST;
    logic        ARVALID, ARREADY, AWVALID, AWREADY;
    logic [3:0]  RID, BID, WSTRB;
    logic [31:0] RDATA;
    logic [1:0]  RRESP, BRESP;
    logic        RLAST, RVALID, RREADY;
    logic        WLAST, WVALID, WREADY;
    logic        BVALID, BREADY;

    int checks = 0;
    int errors = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    dcache_axi_master dut (
        .clk(clk), .rst(rst),
        .D_req(D_req), .D_addr(D_addr), .D_write(D_write), .D_in(D_in), .D_type(D_type),
        .D_out(D_out), .busy(busy), .resp_err(resp_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'h5A5A_3C3C;
    endfunction

    task automatic abort_run(input string what);
        errors++;
        $display("FAIL %s: timed out waiting for DUT", what);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic test_reset();
        rst = 1'b1; D_req = 0; D_write = 0; D_addr = 0; D_in = 0; D_type = CACHE_WORD;
        ARREADY = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
        AWREADY = 0; WREADY = 0; BID = 0; BRESP = 0; BVALID = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, ARVALID, RREADY, AWVALID, WVALID, BREADY, resp_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state: got %b want 0000000",
                     {busy, ARVALID, RREADY, AWVALID, WVALID, BREADY, resp_err});
        end
        exp_err = 1'b0;
    endtask

    // Read: ar_dly cycles of ARREADY stall, bad_beat gets RRESP=SLVERR
    // (-1 = none), short_n > 0 ends the burst early with RLAST.
    task automatic run_read(input logic [31:0] a, input int ar_dly,
                            input int bad_beat, input int short_n);
        logic        cached;
        logic [31:0] ea, dv;
        logic [3:0]  el;
        int nb, to;
        cached = (a[31:16] != 16'h1000) && (a[31:16] != 16'h6000);
        ea = cached ? (a & 32'hFFFF_FFF0) : a;
        el = cached ? 4'd3 : 4'd0;
        nb = cached ? 4 : 1;
        if (short_n > 0 && short_n < nb) begin
            nb = short_n;
            exp_err = 1'b1;
        end
        D_addr = a; D_type = CACHE_WORD; D_req = 1'b1;
        checks++;
        if (ARVALID !== 1'b0) begin
            errors++; $display("FAIL rd_capture_novalid: ARVALID=%b want 0", ARVALID);
        end
        to = 0;
        do begin @(negedge clk); to++; end while (ARVALID !== 1'b1 && to < 8);
        if (ARVALID !== 1'b1) abort_run("rd_arvalid");
        checks++;
        if (ARADDR !== ea || ARLEN !== el || ARSIZE !== 3'b010 || ARBURST !== 2'b01 || ARID !== 4'd1) begin
            errors++;
            $display("FAIL rd_ar_fields: addr=%h len=%0d size=%b burst=%b id=%0d want addr=%h len=%0d size=010 burst=01 id=1",
                     ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ea, el);
        end
        for (int i = 0; i < ar_dly; i++) begin
            @(negedge clk);
            checks++;
            if (ARVALID !== 1'b1 || ARADDR !== ea) begin
                errors++; $display("FAIL rd_ar_stable: valid=%b addr=%h want 1 %h", ARVALID, ARADDR, ea);
            end
        end
        ARREADY = 1'b1;
        @(negedge clk);
        ARREADY = 1'b0;
        checks++;
        if (RREADY !== 1'b1 || ARVALID !== 1'b0) begin
            errors++; $display("FAIL rd_enter_r: rready=%b arvalid=%b want 1 0", RREADY, ARVALID);
        end
        for (int i = 0; i < nb; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            dv = mem_word(ea + 32'(4 * i));
            RVALID = 1'b1; RDATA = dv; RLAST = (i == nb - 1);
            RRESP = (i == bad_beat) ? 2'b10 : 2'b00;
            if (i == bad_beat) exp_err = 1'b1;
            #1;
            checks++;
            if (D_out !== dv || RREADY !== 1'b1) begin
                errors++; $display("FAIL rd_beat%0d: d_out=%h rready=%b want %h 1", i, D_out, RREADY, dv);
            end
            @(negedge clk);
            RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
        end
        checks++;
        if (busy !== 1'b1 || RREADY !== 1'b0) begin
            errors++; $display("FAIL rd_done: busy=%b rready=%b want 1 0", busy, RREADY);
        end
        D_req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || resp_err !== exp_err) begin
            errors++; $display("FAIL rd_idle: busy=%b resp_err=%b want 0 %b", busy, resp_err, exp_err);
        end
    endtask

    // Write: order 0 = AW and W together, 1 = W first, 2 = AW first.
    task automatic run_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                             input int order, input logic also_req, input logic [1:0] bresp);
        logic [3:0] es;
        int to;
        if (t[1:0] == 2'd0)      es = 4'b0001 << a[1:0];
        else if (t[1:0] == 2'd1) es = a[1] ? 4'b1100 : 4'b0011;
        else                     es = 4'b1111;
        D_addr = a; D_in = d; D_type = t; D_write = 1'b1; D_req = also_req;
        checks++;
        if (AWVALID !== 1'b0 || WVALID !== 1'b0) begin
            errors++; $display("FAIL wr_capture_novalid: awvalid=%b wvalid=%b want 0 0", AWVALID, WVALID);
        end
        to = 0;
        do begin @(negedge clk); to++; end while (AWVALID !== 1'b1 && to < 8);
        if (AWVALID !== 1'b1) abort_run("wr_awvalid");
        checks++;
        if (AWADDR !== a || AWLEN !== 4'd0 || AWBURST !== 2'b01 || AWID !== 4'd1 || WVALID !== 1'b1 ||
            WLAST !== 1'b1 || WDATA !== d || WSTRB !== es || ARVALID !== 1'b0) begin
            errors++;
            $display("FAIL wr_fields: awaddr=%h awlen=%0d id=%0d wvalid=%b wlast=%b wdata=%h wstrb=%b arvalid=%b want %h 0 1 1 1 %h %b 0",
                     AWADDR, AWLEN, AWID, WVALID, WLAST, WDATA, WSTRB, ARVALID, a, d, es);
        end
        if (order == 0) begin
            AWREADY = 1'b1; WREADY = 1'b1;
            @(negedge clk);
            AWREADY = 1'b0; WREADY = 1'b0;
        end else begin
            if (order == 1) WREADY = 1'b1; else AWREADY = 1'b1;
            @(negedge clk);
            WREADY = 1'b0; AWREADY = 1'b0;
            repeat (2) begin
                checks++;
                if ((order == 1 && (WVALID !== 1'b0 || AWVALID !== 1'b1)) ||
                    (order == 2 && (AWVALID !== 1'b0 || WVALID !== 1'b1))) begin
                    errors++; $display("FAIL wr_partial_order%0d: awvalid=%b wvalid=%b", order, AWVALID, WVALID);
                end
                @(negedge clk);
            end
            // The accepted channel stays low while the other is finally taken.
            if (order == 1) AWREADY = 1'b1; else WREADY = 1'b1;
            @(negedge clk);
            AWREADY = 1'b0; WREADY = 1'b0;
        end
        checks++;
        if (AWVALID !== 1'b0 || WVALID !== 1'b0 || BREADY !== 1'b1) begin
            errors++; $display("FAIL wr_enter_b: awvalid=%b wvalid=%b bready=%b want 0 0 1", AWVALID, WVALID, BREADY);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        BVALID = 1'b1; BRESP = bresp;
        if (bresp != 2'b00) exp_err = 1'b1;
        @(negedge clk);
        BVALID = 1'b0; BRESP = 2'b00;
        checks++;
        if (BREADY !== 1'b0 || busy !== 1'b1 || AWVALID !== 1'b0 || WVALID !== 1'b0) begin
            errors++; $display("FAIL wr_single_b: bready=%b busy=%b awvalid=%b wvalid=%b want 0 1 0 0",
                               BREADY, busy, AWVALID, WVALID);
        end
        D_write = 1'b0; D_req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || resp_err !== exp_err) begin
            errors++; $display("FAIL wr_idle: busy=%b resp_err=%b want 0 %b", busy, resp_err, exp_err);
        end
    endtask

    task automatic test_cached_read();
        run_read(32'h0000_1234, 2, -1, 0);
    endtask

    task automatic test_uncached_read();
        run_read(32'h1000_0008, 0, -1, 0);
        run_read(32'h6000_0104, 1, -1, 0);
    endtask

    task automatic test_sb_write();
        run_write(32'h2000_0003, 32'hAB00_0000, CACHE_BYTE, 0, 1'b0, 2'b00);
    endtask

    task automatic test_write_orders();
        run_write(32'h0000_0102, 32'h1234_5678, CACHE_HWORD, 1, 1'b0, 2'b00);
        run_write(32'h0000_0200, 32'hCAFE_F00D, CACHE_WORD, 2, 1'b0, 2'b00);
    endtask

    task automatic test_write_priority();
        run_write(32'h0000_0301, 32'h0000_5500, CACHE_BYTE_U, 0, 1'b1, 2'b00);
    endtask

    task automatic test_back_to_back_random();
        logic [15:0] hi_tab [5];
        logic [2:0]  ty_tab [5];
        logic [31:0] a;
        hi_tab[0] = 16'h0000; hi_tab[1] = 16'h1000; hi_tab[2] = 16'h6000;
        hi_tab[3] = 16'h2000; hi_tab[4] = 16'($urandom);
        ty_tab[0] = CACHE_BYTE; ty_tab[1] = CACHE_HWORD; ty_tab[2] = CACHE_WORD;
        ty_tab[3] = CACHE_BYTE_U; ty_tab[4] = CACHE_HWORD_U;
        for (int n = 0; n < 14; n++) begin
            a = {hi_tab[$urandom_range(0, 4)], 16'($urandom)};
            if ($urandom_range(0, 1) == 0)
                run_read(a, $urandom_range(0, 3), -1, 0);
            else
                run_write(a, $urandom, ty_tab[$urandom_range(0, 4)], $urandom_range(0, 2), 1'b0, 2'b00);
        end
    endtask

    task automatic test_resp_err();
        run_read(32'h0000_4000, 0, 2, 0);
        run_write(32'h0000_4010, 32'h1111_2222, CACHE_WORD, 0, 1'b0, 2'b00);
        run_read(32'h0000_4020, 0, -1, 0);
    endtask

    task automatic test_reset_mid_burst();
        int to;
        D_addr = 32'h0000_8000; D_type = CACHE_WORD; D_req = 1'b1;
        to = 0;
        do begin @(negedge clk); to++; end while (ARVALID !== 1'b1 && to < 8);
        if (ARVALID !== 1'b1) abort_run("rst_arvalid");
        ARREADY = 1'b1;
        @(negedge clk);
        ARREADY = 1'b0;
        RVALID = 1'b1; RDATA = mem_word(32'h0000_8000); RLAST = 1'b0;
        @(negedge clk);
        RVALID = 1'b0;
        rst = 1'b1; D_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        checks++;
        if (ARVALID !== 1'b0 || RREADY !== 1'b0 || busy !== 1'b0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_burst: arvalid=%b rready=%b busy=%b resp_err=%b want 0 0 0 0",
                               ARVALID, RREADY, busy, resp_err);
        end
        run_read(32'h0000_8040, 1, -1, 0);
    endtask

    task automatic test_short_burst();
        run_read(32'h0000_9000, 0, -1, 2);
    endtask

    task automatic test_bresp_err();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        run_write(32'h0000_A000, 32'h0BAD_0BAD, CACHE_WORD, 0, 1'b0, 2'b11);
    endtask

    initial begin
        test_reset();
        test_cached_read();
        test_uncached_read();
        test_sb_write();
        test_write_orders();
        test_write_priority();
        test_back_to_back_random();
        test_resp_err();
        test_reset_mid_burst();
        test_short_burst();
        test_bresp_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
